array_mp: RTL and testbench

//  Parametrised two-port successor of the single-port array store: async read, sync write on two

---
 rtl/array_mp.sv | 141 ++++++++++++++
 tb/tb_array_mp.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/array_mp.sv
`default_nettype none
// ============================================================================
// Module   : array_mp
// Purpose  : Two-port valid/ready scratch memory. Async read, sync write.
//            Self-fills after reset. Sticky out-of-range flag.
// Options  : ARRAY_MP_BYPASS_EN enables write-to-read forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module array_mp #(
    parameter int          N         = 16,
    parameter int          AW        = 4,
    parameter int          DW        = 32,
    parameter int          INIT_ADDR = 1,
    parameter logic [DW-1:0] INIT    = '0
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          out0_ready,
    output logic          out0_valid,
    input  logic [AW-1:0] out0_addr,
    input  logic          out0_we,
    input  logic [DW-1:0] out0_di,
    output logic [DW-1:0] out0,
    input  logic          out1_ready,
    output logic          out1_valid,
    input  logic [AW-1:0] out1_addr,
    input  logic          out1_we,
    input  logic [DW-1:0] out1_di,
    output logic [DW-1:0] out1,
    output logic          init_done,
    output logic          oob
);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [AW-1:0] c_last = AW'(N - 1);

    state_t          r_state;
    logic [AW-1:0]   r_fill_ptr;
    logic            r_init_done;
    logic            r_oob;
    logic [DW-1:0]   r_mem [N];

    logic            w_run;
    logic            w_inr0;
    logic            w_inr1;
    logic            w_wr0;
    logic            w_wr1;
    logic            w_oob_hit;
    logic [DW-1:0]   w_fill_val;
    logic [DW-1:0]   w_out0;
    logic [DW-1:0]   w_out1;

    assign w_run      = (r_state == S_RUN);
    assign w_inr0     = (32'(out0_addr) < 32'(N));
    assign w_inr1     = (32'(out1_addr) < 32'(N));
    assign out0_valid = w_run & out0_ready;
    assign out1_valid = w_run & out1_ready;
    assign w_wr0      = out0_valid & out0_we & w_inr0;
    // Port 1 loses a same-address collision with port 0.
    assign w_wr1      = out1_valid & out1_we & w_inr1 &
                        ~(w_wr0 & (out0_addr == out1_addr));
    assign w_oob_hit  = (out0_valid & ~w_inr0) | (out1_valid & ~w_inr1);
    assign w_fill_val = (INIT_ADDR != 0) ? DW'(r_fill_ptr) : INIT;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= S_FILL;
            r_fill_ptr  <= '0;
            r_init_done <= 1'b0;
            r_oob       <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (r_fill_ptr == c_last) begin
                        r_state     <= S_RUN;
                        r_init_done <= 1'b1;
                    end else begin
                        r_fill_ptr  <= r_fill_ptr + 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_oob_hit) begin
                        r_oob <= 1'b1;
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    // Storage is deliberately not reset; the fill sequence rewrites every entry.
    always_ff @(posedge clk) begin
        if (r_state == S_FILL) begin
            if (nrst) begin
                r_mem[r_fill_ptr] <= w_fill_val;
            end
        end else begin
            if (w_wr0) begin
                r_mem[out0_addr] <= out0_di;
            end
            if (w_wr1) begin
                r_mem[out1_addr] <= out1_di;
            end
        end
    end

    always_comb begin
        w_out0 = '0;
        w_out1 = '0;
        if (w_run && w_inr0) begin
            w_out0 = r_mem[out0_addr];
        end
        if (w_run && w_inr1) begin
            w_out1 = r_mem[out1_addr];
        end
`ifdef ARRAY_MP_BYPASS_EN
        if (w_wr0) begin
            w_out0 = out0_di;
        end else if (w_wr1 && (out1_addr == out0_addr)) begin
            w_out0 = out1_di;
        end
        if (w_wr0 && (out0_addr == out1_addr)) begin
            w_out1 = out0_di;
        end else if (w_wr1) begin
            w_out1 = out1_di;
        end
`else
`endif
    end

    assign out0      = w_out0;
    assign out1      = w_out1;
    assign init_done = r_init_done;
    assign oob       = r_oob;

endmodule
`default_nettype wire

// File: tb/tb_array_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_array_mp
// Purpose  : Directed self-checking bench for array_mp (N=16 and N=12 builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_array_mp;

    localparam int AW = 4;
    localparam int DW = 32;
`ifdef ARRAY_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk  = 1'b0;
    logic nrst = 1'b1;
    always #5 clk = ~clk;

    logic          a_ready0, a_ready1, a_we0, a_we1, a_valid0, a_valid1, a_init_done, a_oob;
    logic [AW-1:0] a_addr0, a_addr1;
    logic [DW-1:0] a_di0, a_di1, a_out0, a_out1;
    logic          b_ready0, b_ready1, b_we0, b_we1, b_valid0, b_valid1, b_init_done, b_oob;
    logic [AW-1:0] b_addr0, b_addr1;
    logic [DW-1:0] b_di0, b_di1, b_out0, b_out1;

    int n_checks = 0;
    int n_fail   = 0;

    array_mp #(.N(16), .AW(AW), .DW(DW), .INIT_ADDR(1), .INIT('0)) u_dut_a (
        .clk(clk), .nrst(nrst),
        .out0_ready(a_ready0), .out0_valid(a_valid0), .out0_addr(a_addr0),
        .out0_we(a_we0), .out0_di(a_di0), .out0(a_out0),
        .out1_ready(a_ready1), .out1_valid(a_valid1), .out1_addr(a_addr1),
        .out1_we(a_we1), .out1_di(a_di1), .out1(a_out1),
        .init_done(a_init_done), .oob(a_oob)
    );

    array_mp #(.N(12), .AW(AW), .DW(DW), .INIT_ADDR(1), .INIT('0)) u_dut_b (
        .clk(clk), .nrst(nrst),
        .out0_ready(b_ready0), .out0_valid(b_valid0), .out0_addr(b_addr0),
        .out0_we(b_we0), .out0_di(b_di0), .out0(b_out0),
        .out1_ready(b_ready1), .out1_valid(b_valid1), .out1_addr(b_addr1),
        .out1_we(b_we1), .out1_di(b_di1), .out1(b_out1),
        .init_done(b_init_done), .oob(b_oob)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_ready0 = 1'b1; a_ready1 = 1'b1; a_we0 = 1'b0; a_we1 = 1'b0;
        a_addr0 = '0; a_addr1 = '0; a_di0 = '0; a_di1 = '0;
        b_ready0 = 1'b0; b_ready1 = 1'b0; b_we0 = 1'b0; b_we1 = 1'b0;
        b_addr0 = '0; b_addr1 = '0; b_di0 = '0; b_di1 = '0;

        // Reset state
        #2 nrst = 1'b0;
        #1;
        check("rst_init_done", a_init_done, 0);
        check("rst_oob", a_oob, 0);
        check("rst_valid0", a_valid0, 0);
        check("rst_valid1", a_valid1, 0);
        check("rst_out0", a_out0, 0);
        tick;
        tick;
        check("rst_hold_valid0", a_valid0, 0);

        // Fill takes exactly 16 cycles after release
        nrst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick;
            check("fill_init_done", a_init_done, (i == 15));
            check("fill_valid0", a_valid0, (i == 15));
        end
        check("b_init_done", b_init_done, 1);

        a_addr0 = 4'd5; a_addr1 = 4'd5;
        #1;
        check("rd5_p0", a_out0, 32'd5);
        check("rd5_p1", a_out1, 32'd5);

        // Two independent writes in one cycle
        a_we0 = 1'b1; a_addr0 = 4'd3; a_di0 = 32'hAA;
        a_we1 = 1'b1; a_addr1 = 4'd9; a_di1 = 32'h55;
        tick;
        a_we0 = 1'b0; a_we1 = 1'b0;
        #1;
        check("wr3_p0", a_out0, 32'hAA);
        check("wr9_p1", a_out1, 32'h55);

        // Same-address collision: port 0 wins
        a_we0 = 1'b1; a_addr0 = 4'd7; a_di0 = 32'h11;
        a_we1 = 1'b1; a_addr1 = 4'd7; a_di1 = 32'h22;
        #1;
        check("coll_rdw_p1", a_out1, BYP ? 32'h11 : 32'd7);
        tick;
        a_we0 = 1'b0; a_we1 = 1'b0;
        #1;
        check("coll_p0", a_out0, 32'h11);
        check("coll_p1", a_out1, 32'h11);
        check("coll_oob", a_oob, 0);

        // Cross-port read-during-write
        a_we1 = 1'b1; a_addr1 = 4'd15; a_di1 = 32'hBEEF; a_addr0 = 4'd15;
        #1;
        check("rdw15_p0", a_out0, BYP ? 32'hBEEF : 32'd15);
        tick;
        a_we1 = 1'b0;
        #1;
        check("wr15_p0", a_out0, 32'hBEEF);
        check("wr15_p1", a_out1, 32'hBEEF);

        // Write without ready is not accepted
        a_ready0 = 1'b0; a_we0 = 1'b1; a_addr0 = 4'd2; a_di0 = 32'h99; a_addr1 = 4'd2;
        #1;
        check("noready_valid0", a_valid0, 0);
        check("ready_valid1", a_valid1, 1);
        tick;
        a_we0 = 1'b0; a_ready0 = 1'b1;
        #1;
        check("noready_p0", a_out0, 32'd2);
        check("noready_p1", a_out1, 32'd2);

        // Out-of-range access on the N=12 instance
        b_ready0 = 1'b1; b_we0 = 1'b1; b_addr0 = 4'd13; b_di0 = 32'h77;
        #1;
        check("b_valid0", b_valid0, 1);
        check("b_oob_before", b_oob, 0);
        check("b_rd13_live", b_out0, 0);
        tick;
        b_we0 = 1'b0; b_ready0 = 1'b0;
        #1;
        check("b_oob_set", b_oob, 1);
        tick;
        check("b_oob_sticky", b_oob, 1);
        check("b_rd13", b_out0, 0);
        for (int j = 0; j < 12; j++) begin
            b_addr1 = AW'(j);
            #1;
            check("b_entry", b_out1, DW'(j));
        end

        // Reset asserted mid-fill restarts the full sequence
        nrst = 1'b0;
        #1;
        check("rst2_init_done", a_init_done, 0);
        check("rst2_valid0", a_valid0, 0);
        check("rst2_b_oob", b_oob, 0);
        tick;
        nrst = 1'b1;
        repeat (6) tick;
        nrst = 1'b0;
        #1;
        check("rst3_init_done", a_init_done, 0);
        tick;
        nrst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick;
            check("refill_init_done", a_init_done, (i == 15));
        end
        a_addr0 = 4'd3; a_addr1 = 4'd7;
        #1;
        check("refill_rd3", a_out0, 32'd3);
        check("refill_rd7", a_out1, 32'd7);
        a_addr0 = 4'd15; a_addr1 = 4'd9;
        #1;
        check("refill_rd15", a_out0, 32'd15);
        check("refill_rd9", a_out1, 32'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
